ysyx_25040101_core_mc: RTL and testbench
========================================

# ysyx_25040101_core_mc

Parametrised multi-cycle successor to the single-cycle RV32 core top. It replaces the fixed combinational fetch with valid/ready handshakes to separate instruction and data memories, sequenced by a state machine. It adds loads and stores, jumps, U-type instructions, a configurable reset vector and register count (RV32I/RV32E), and a halt/illegal-instruction status. It sits between the simulation memory model and the testbench, one level above the register file.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value after reset.
- `NREGS`, default 32: architectural register count, legal values 32 or 16.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `imem_req_valid` output 1: fetch request.
- `imem_req_ready` input 1: fetch request accepted.
- `imem_addr` output 32: fetch address, equal to the PC.
- `imem_rsp_valid` input 1: instruction returned.
- `imem_rdata` input 32: instruction word.
- `dmem_req_valid` output 1: data request.
- `dmem_req_ready` input 1: data request accepted.
- `dmem_we` output 1: 1 = store, 0 = load.
- `dmem_addr` output 32: word-aligned byte address.
- `dmem_wdata` output 32: store data (rs2).
- `dmem_wmask` output 4: byte enables, 4'hF for stores, 4'h0 for loads.
- `dmem_rsp_valid` input 1: load data valid, or store completion.
- `dmem_rdata` input 32: load data.
- `halt` output 1: sticky once set.
- `illegal` output 1: sticky; the halt was caused by an illegal or misaligned instruction.
- `halt_code` output 32: value of a0 (x10) captured at halt.

## Operation
- Supported instructions: `add`, `sub`, `addi`, `lui`, `auipc`, `jal`, `jalr`, `lw`, `sw`, `ebreak`.
- Every other encoding is illegal. The following are also illegal:
  - any register index >= NREGS;
  - a misaligned `lw`/`sw` address;
  - a jump target with bit[1] set.
- States:
  - IF_REQ: `imem_req_valid`=1. On `imem_req_ready` go to IF_WAIT.
  - IF_WAIT: on `imem_rsp_valid`, latch the instruction into IR and go to EXEC.
  - EXEC: decode IR and compute through the ALU/extend path.
    - ALU, U-type and jumps: write rd, update PC, go to IF_REQ.
    - `lw`/`sw`: latch address and data, go to MEM_REQ.
    - `ebreak` or illegal: go to HALT.
  - MEM_REQ: `dmem_req_valid`=1. On `dmem_req_ready` go to MEM_WAIT.
  - MEM_WAIT: on `dmem_rsp_valid`:
    - `lw` writes `dmem_rdata` to rd;
    - PC += 4;
    - go to IF_REQ.
  - HALT: terminal. Only `rst` exits it.
- Writes to x0 are discarded, and x0 always reads 0.
- `jal`/`jalr` write PC+4 to rd. The `jalr` target is (rs1+imm) with bit0 cleared.
- All arithmetic is 32-bit modulo 2^32. Overflow is ignored.
- Request address/data outputs hold stable while valid=1 and ready=0.
- A response is accepted only in the matching WAIT state. Responses arriving in other states are ignored.
- `halt_code` is captured on entry to HALT, from a0 as read in that EXEC cycle.
- With NREGS=16, a0 still maps to x10.

## Timing
- Reset (`rst`=0 at a clock edge):
  - PC=RESET_PC, state=IF_REQ;
  - all valids=0, `halt`=0, `illegal`=0, `halt_code`=0;
  - register file cleared to 0.
- Reset asserted mid-transaction: any outstanding request is abandoned. Its later response arrives in IF_REQ and is therefore ignored.
- Minimum cycles per instruction with ready=1 and a response one cycle after acceptance:
  - ALU/jump: 3 (IF_REQ, IF_WAIT, EXEC);
  - `lw`/`sw`: 5;
  - each stall cycle on ready or rsp_valid adds one.
- Register write and PC update take effect at the end of EXEC or MEM_WAIT. The next IF_REQ presents the new PC.
- `halt` rises in the cycle after the halting EXEC and remains 1.

## Structure
- Package `ysyx_25040101_pkg` holds:
  - the state enum;
  - opcode, funct3 and funct7 constants;
  - immediate-type codes (I/S/B/U/J);
  - the ALU-op enum.
- Sub-module `ysyx_25040101_regs_p`:
  - parameter NREGS;
  - two combinational read ports, one synchronous write port;
  - x0 hardwired to 0;
  - a0 tap output.
- Decoder, immediate extension and ALU stay inline in the core FSM.

## Test plan
- Reset and fetch: hold `rst`=0 for 3 cycles, then release. Required: `imem_addr`=32'h8000_0000 and `imem_req_valid`=1 in the first post-reset cycle. `addi x1,x0,5` then `addi x1,x1,-7` leaves x1=32'hFFFF_FFFE.
- Handshake stalls: hold `imem_req_ready`=0 for 4 cycles and delay `imem_rsp_valid` by 3 cycles. Required: `imem_addr` stays constant throughout, and the instruction retires after 3+4+3 = 10 cycles.
- Load/store: `lui x2,0x80001`; `addi x3,x0,0x55`; `sw x3,8(x2)`; `lw x4,8(x2)`. Required: `dmem_addr`=32'h8000_1008, `dmem_wmask`=4'hF, `dmem_wdata`=32'h55, and x4=32'h55.
- Jumps: `jal x1,+8` at 32'h8000_0000. Required: x1=32'h8000_0004 and next fetch at 32'h8000_0008. Then `jalr x0,0(x1)` makes the next fetch 32'h8000_0004.
- Halt: `addi a0,x0,0` then `ebreak`. Required: `halt`=1, `illegal`=0, `halt_code`=0, and no further requests. Instruction word 32'h0000_0000 gives `illegal`=1.
- RV32E: with NREGS=16, `addi x20,x0,1`. Required: `halt`=1 and `illegal`=1. Then a mid-MEM_WAIT reset restarts fetch at RESET_PC.

Source files
------------

// File: rtl/ysyx_25040101_pkg.sv
// Shared types and encodings for the multi-cycle RV32I/E core.
package ysyx_25040101_pkg;

  typedef enum logic [2:0] {
    S_IF_REQ,
    S_IF_WAIT,
    S_EXEC,
    S_MEM_REQ,
    S_MEM_WAIT,
    S_HALT
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_W    = 3'b010;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_PASSB} alu_e;

  // Sign/zero extension of the immediate field for each encoding format.
  function automatic logic [31:0] imm_ext(input logic [31:0] ir, input imm_e t);
    logic [31:0] r;
    case (t)
      IMM_I:   r = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   r = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   r = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   r = {ir[31:12], 12'b0};
      IMM_J:   r = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_25040101_regs_p.sv
// Architectural register file: two async read ports, one sync write port,
// x0 hardwired to zero, a0 exposed for halt-code capture.
module ysyx_25040101_regs_p
  import ysyx_25040101_pkg::*;
#(
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [31:0]   rdata1_o,
  output logic [31:0]   rdata2_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   a0_o
);

  logic [31:0] rf_q [NREGS];

  // Clear on reset; writes to x0 are dropped so it always reads zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : rf_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : rf_q[raddr2_i];
  assign a0_o     = rf_q[10];

endmodule

// File: rtl/ysyx_25040101_core_mc.sv
// Multi-cycle RV32I/E core: handshaked instruction and data memories,
// sequenced by a fetch/exec/mem FSM, with sticky halt/illegal status.
module ysyx_25040101_core_mc
  import ysyx_25040101_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rdata,
  output logic        halt,
  output logic        illegal,
  output logic [31:0] halt_code
);

  localparam int         AW = $clog2(NREGS);
  localparam logic [5:0] NR = 6'(NREGS);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic        mwe_q, mwe_d;
  logic        halt_q, halt_d;
  logic        illegal_q, illegal_d;
  logic [31:0] hcode_q, hcode_d;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [2:0]  f3;
  logic [31:0] rs1_v, rs2_v, a0_v;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign opcode = ir_q[6:0];
  assign rd_f   = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1_f  = ir_q[19:15];
  assign rs2_f  = ir_q[24:20];
  assign f7     = ir_q[31:25];

  ysyx_25040101_regs_p #(.NREGS(NREGS)) u_regs (
    .clk      (clk),
    .rst      (rst),
    .raddr1_i (rs1_f[AW-1:0]),
    .raddr2_i (rs2_f[AW-1:0]),
    .rdata1_o (rs1_v),
    .rdata2_o (rs2_v),
    .we_i     (rf_we),
    .waddr_i  (rd_f[AW-1:0]),
    .wdata_i  (rf_wdata),
    .a0_o     (a0_v)
  );

  logic legal, is_ebreak, is_mem, is_store, is_jump, wr_rd, use_rs1, use_rs2;
  logic a_pc, b_imm;
  imm_e imm_t;
  alu_e alu_op;

  // Decode IR into control bits; anything not matched stays illegal.
  always_comb begin
    legal = 1'b0; is_ebreak = 1'b0; is_mem = 1'b0; is_store = 1'b0;
    is_jump = 1'b0; wr_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    a_pc = 1'b0; b_imm = 1'b1; imm_t = IMM_I; alu_op = ALU_ADD;
    case (opcode)
      OP_OP: if (f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) begin
        legal = 1'b1; wr_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        b_imm = 1'b0; alu_op = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
      end
      OP_IMM: if (f3 == F3_ADD) begin
        legal = 1'b1; wr_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_LUI: begin
        legal = 1'b1; wr_rd = 1'b1; imm_t = IMM_U; alu_op = ALU_PASSB;
      end
      OP_AUIPC: begin
        legal = 1'b1; wr_rd = 1'b1; imm_t = IMM_U; a_pc = 1'b1;
      end
      OP_JAL: begin
        legal = 1'b1; wr_rd = 1'b1; is_jump = 1'b1; imm_t = IMM_J; a_pc = 1'b1;
      end
      OP_JALR: if (f3 == F3_JALR) begin
        legal = 1'b1; wr_rd = 1'b1; is_jump = 1'b1; use_rs1 = 1'b1;
      end
      OP_LOAD: if (f3 == F3_W) begin
        legal = 1'b1; wr_rd = 1'b1; is_mem = 1'b1; use_rs1 = 1'b1;
      end
      OP_STORE: if (f3 == F3_W) begin
        legal = 1'b1; is_mem = 1'b1; is_store = 1'b1; use_rs1 = 1'b1;
        use_rs2 = 1'b1; imm_t = IMM_S;
      end
      OP_SYSTEM: if (ir_q == INSN_EBREAK) begin
        legal = 1'b1; is_ebreak = 1'b1;
      end
      default: ;
    endcase
  end

  logic [31:0] imm, opa, opb, alu_res, jtgt, pc4;
  logic        bad_idx, misalign, bad;

  // ALU/extend datapath plus the legality checks that depend on its result.
  always_comb begin
    imm = imm_ext(ir_q, imm_t);
    opa = a_pc ? pc_q : rs1_v;
    opb = b_imm ? imm : rs2_v;
    case (alu_op)
      ALU_SUB:   alu_res = opa - opb;
      ALU_PASSB: alu_res = opb;
      default:   alu_res = opa + opb;
    endcase
    jtgt     = {alu_res[31:1], 1'b0};
    pc4      = pc_q + 32'd4;
    bad_idx  = (wr_rd   && ({1'b0, rd_f}  >= NR)) ||
               (use_rs1 && ({1'b0, rs1_f} >= NR)) ||
               (use_rs2 && ({1'b0, rs2_f} >= NR));
    misalign = (is_jump && jtgt[1]) || (is_mem && (alu_res[1:0] != 2'b00));
    bad      = !legal || bad_idx || misalign;
  end

  // Next-state and datapath register control for the multi-cycle sequence.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    mwe_d     = mwe_q;
    halt_d    = halt_q;
    illegal_d = illegal_q;
    hcode_d   = hcode_q;
    rf_we     = 1'b0;
    rf_wdata  = alu_res;
    case (state_q)
      S_IF_REQ:  if (imem_req_ready) state_d = S_IF_WAIT;
      S_IF_WAIT: if (imem_rsp_valid) begin
        ir_d    = imem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bad || is_ebreak) begin
          halt_d    = 1'b1;
          illegal_d = bad;
          hcode_d   = a0_v;
          state_d   = S_HALT;
        end else if (is_mem) begin
          maddr_d  = alu_res;
          mwdata_d = rs2_v;
          mwe_d    = is_store;
          state_d  = S_MEM_REQ;
        end else begin
          rf_we    = wr_rd;
          rf_wdata = is_jump ? pc4 : alu_res;
          pc_d     = is_jump ? jtgt : pc4;
          state_d  = S_IF_REQ;
        end
      end
      S_MEM_REQ: if (dmem_req_ready) state_d = S_MEM_WAIT;
      S_MEM_WAIT: if (dmem_rsp_valid) begin
        rf_we    = !mwe_q;
        rf_wdata = dmem_rdata;
        pc_d     = pc4;
        state_d  = S_IF_REQ;
      end
      default: ;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IF_REQ;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      mwe_q     <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
      hcode_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      mwe_q     <= mwe_d;
      halt_q    <= halt_d;
      illegal_q <= illegal_d;
      hcode_q   <= hcode_d;
    end
  end

  // Request valids are masked while reset is held so nothing is issued then.
  assign imem_req_valid = rst && (state_q == S_IF_REQ);
  assign imem_addr      = pc_q;
  assign dmem_req_valid = rst && (state_q == S_MEM_REQ);
  assign dmem_we        = mwe_q;
  assign dmem_addr      = maddr_q;
  assign dmem_wdata     = mwdata_q;
  assign dmem_wmask     = mwe_q ? 4'hF : 4'h0;
  assign halt           = halt_q;
  assign illegal        = illegal_q;
  assign halt_code      = hcode_q;

endmodule

// File: tb/tb_ysyx_25040101_core_mc.sv
// Directed bench: RV32I instance plus an RV32E instance sharing one memory model.
module tb_ysyx_25040101_core_mc;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, rst_e = 1'b0, sel = 1'b0;
  logic imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
  logic [31:0] dmem_rdata = '0;

  logic a_iv, a_dv, a_dwe, a_halt, a_ill;
  logic [31:0] a_ia, a_da, a_dwd, a_hc;
  logic [3:0]  a_dwm;
  logic e_iv, e_dv, e_dwe, e_halt, e_ill;
  logic [31:0] e_ia, e_da, e_dwd, e_hc;
  logic [3:0]  e_dwm;

  ysyx_25040101_core_mc dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(a_iv), .imem_req_ready(imem_req_ready), .imem_addr(a_ia),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .dmem_req_valid(a_dv), .dmem_req_ready(dmem_req_ready), .dmem_we(a_dwe),
    .dmem_addr(a_da), .dmem_wdata(a_dwd), .dmem_wmask(a_dwm),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .halt(a_halt), .illegal(a_ill), .halt_code(a_hc));

  ysyx_25040101_core_mc #(.NREGS(16)) dut_e (
    .clk(clk), .rst(rst_e),
    .imem_req_valid(e_iv), .imem_req_ready(imem_req_ready), .imem_addr(e_ia),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .dmem_req_valid(e_dv), .dmem_req_ready(dmem_req_ready), .dmem_we(e_dwe),
    .dmem_addr(e_da), .dmem_wdata(e_dwd), .dmem_wmask(e_dwm),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .halt(e_halt), .illegal(e_ill), .halt_code(e_hc));

  // View of whichever core is currently under test.
  wire        m_iv   = sel ? e_iv   : a_iv;
  wire [31:0] m_ia   = sel ? e_ia   : a_ia;
  wire        m_dv   = sel ? e_dv   : a_dv;
  wire        m_dwe  = sel ? e_dwe  : a_dwe;
  wire [31:0] m_da   = sel ? e_da   : a_da;
  wire [31:0] m_dwd  = sel ? e_dwd  : a_dwd;
  wire [3:0]  m_dwm  = sel ? e_dwm  : a_dwm;
  wire        m_halt = sel ? e_halt : a_halt;
  wire        m_ill  = sel ? e_ill  : a_ill;
  wire [31:0] m_hc   = sel ? e_hc   : a_hc;

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] flog [$];
  int istall = 0, idelay = 0, ddelay = 0, iwait = 0, dwait = 0, dacc = 0;
  bit ipend = 0, dpend = 0, prev_stall = 0;
  int unstable = 0;
  logic [31:0] iaddr = '0, daddr = '0, prev_ia = '0;
  logic [31:0] st_addr = '0, st_wdata = '0, ld_addr = '0;
  logic [3:0]  st_wmask = '0, ld_wmask = '0;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory responder: drives ready/rsp on the falling edge, one-shot stall knobs.
  initial begin
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (ipend) begin
        if (iwait == 0) begin
          imem_rsp_valid = 1'b1; imem_rdata = imem[iaddr[7:2]]; ipend = 0;
        end else iwait--;
      end
      imem_req_ready = 1'b0;
      if (m_iv) begin
        if (istall > 0) istall--;
        else begin
          imem_req_ready = 1'b1; ipend = 1; iwait = idelay; idelay = 0;
          iaddr = m_ia; flog.push_back(m_ia);
        end
      end
      if (prev_stall && m_iv && (m_ia != prev_ia)) unstable++;
      prev_stall = m_iv && !imem_req_ready;
      prev_ia    = m_ia;

      dmem_rsp_valid = 1'b0;
      if (dpend) begin
        if (dwait == 0) begin
          dmem_rsp_valid = 1'b1; dmem_rdata = dmem[daddr[7:2]]; dpend = 0;
        end else dwait--;
      end
      dmem_req_ready = 1'b0;
      if (m_dv) begin
        dmem_req_ready = 1'b1; dpend = 1; dwait = ddelay; ddelay = 0;
        daddr = m_da; dacc++;
        if (m_dwe) begin
          st_addr = m_da; st_wdata = m_dwd; st_wmask = m_dwm;
          dmem[m_da[7:2]] = m_dwd;
        end else begin
          ld_addr = m_da; ld_wmask = m_dwm;
        end
      end
    end
  end

  task automatic clr();
    foreach (imem[i]) imem[i] = '0;
  endtask

  // Hold reset for 3 edges, release, return at the falling edge of the first run cycle.
  task automatic do_reset(input bit e);
    sel = e; rst = 1'b0; rst_e = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    flog.delete();
    if (e) rst_e = 1'b1; else rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_halt();
    int n = 0;
    while (!m_halt && n < 400) begin @(negedge clk); n++; end
    chk("halt_reached", 32'(m_halt), 1);
  endtask

  // Number of cycles the fetch address sits at a.
  task automatic cycles_at(input logic [31:0] a, output int n);
    int t = 0;
    n = 0;
    while (m_ia != a && t < 200) begin @(negedge clk); t++; end
    while (m_ia == a && n < 200) begin @(negedge clk); n++; end
  endtask

  initial begin
    int n, reqs, old;
    logic [31:0] ill_vec [3];
    ill_vec[0] = 32'h0000_0000;  // all-zero word
    ill_vec[1] = 32'h0020_2203;  // lw x4,2(x0): misaligned
    ill_vec[2] = 32'h0020_0067;  // jalr x0,2(x0): target bit1 set
    foreach (dmem[i]) dmem[i] = '0;

    // auipc
    clr(); imem[0] = 32'h0000_1517; imem[1] = EBRK;
    do_reset(0); wait_halt();
    chk("auipc_a0", m_hc, 32'h8000_1000);

    // reset state, then ALU sequence incl. x0 write discard
    rst = 1'b0; @(posedge clk); #1;
    chk("rst_ivalid", 32'(m_iv), 0);
    chk("rst_halt", 32'(m_halt), 0);
    chk("rst_hcode", m_hc, 0);
    clr();
    imem[0] = 32'h0050_0093; imem[1] = 32'hFF90_8093; imem[2] = 32'h0070_0013;
    imem[3] = 32'h4010_02B3; imem[4] = 32'h0010_8533; imem[5] = 32'h4055_0533;
    imem[6] = EBRK;
    do_reset(0);
    chk("rst_iaddr", m_ia, BASE);
    chk("rst_ivalid1", 32'(m_iv), 1);
    chk("rst_illegal", 32'(m_ill), 0);
    chk("rst_dvalid", 32'(m_dv), 0);
    cycles_at(BASE, n);
    chk("alu_cycles", n, 3);
    wait_halt();
    chk("alu_a0", m_hc, 32'hFFFF_FFFA);
    chk("alu_illegal", 32'(m_ill), 0);

    // handshake stalls
    clr(); imem[0] = 32'h0050_0093; imem[1] = EBRK;
    istall = 4; idelay = 3; unstable = 0;
    do_reset(0);
    cycles_at(BASE, n);
    chk("stall_cycles", n, 10);
    chk("stall_addr_stable", unstable, 0);
    wait_halt();

    // load/store
    clr();
    imem[0] = 32'h8000_1137; imem[1] = 32'h0550_0193; imem[2] = 32'h0031_2423;
    imem[3] = 32'h0081_2203; imem[4] = 32'h0002_0513; imem[5] = EBRK;
    do_reset(0);
    cycles_at(BASE + 8, n);
    chk("sw_cycles", n, 5);
    cycles_at(BASE + 12, n);
    chk("lw_cycles", n, 5);
    wait_halt();
    chk("sw_addr", st_addr, 32'h8000_1008);
    chk("sw_wmask", 32'(st_wmask), 32'hF);
    chk("sw_wdata", st_wdata, 32'h55);
    chk("lw_addr", ld_addr, 32'h8000_1008);
    chk("lw_wmask", 32'(ld_wmask), 0);
    chk("lw_x4", m_hc, 32'h55);

    // jumps: jal x1,+8 ; jal x1,+8 ; jalr x0,0(x1) ; addi a0,x1,0 ; ebreak
    clr();
    imem[0] = 32'h0080_00EF; imem[1] = 32'h0080_00EF; imem[2] = 32'h0000_8067;
    imem[3] = 32'h0000_8513; imem[4] = EBRK;
    do_reset(0); wait_halt();
    chk("jmp_nfetch", flog.size(), 5);
    if (flog.size() == 5) begin
      chk("jmp_f1", flog[1], BASE + 8);
      chk("jmp_f2", flog[2], BASE + 4);
      chk("jmp_f3", flog[3], BASE + 12);
    end
    chk("jmp_x1", m_hc, 32'h8000_0008);

    // ebreak halt, no further requests
    clr(); imem[0] = 32'h0000_0513; imem[1] = EBRK;
    do_reset(0); wait_halt();
    chk("halt_illegal", 32'(m_ill), 0);
    chk("halt_code0", m_hc, 0);
    reqs = 0;
    repeat (10) begin @(negedge clk); reqs += int'(m_iv) + int'(m_dv); end
    chk("halt_no_req", reqs, 0);
    chk("halt_sticky", 32'(m_halt), 1);

    // illegal encodings
    foreach (ill_vec[k]) begin
      clr(); imem[0] = ill_vec[k];
      do_reset(0); wait_halt();
      chk($sformatf("illegal_%0d", k), 32'(m_ill), 1);
    end

    // RV32E: x20 is out of range
    clr(); imem[0] = 32'h0010_0A13; imem[1] = EBRK;
    do_reset(1); wait_halt();
    chk("e_illegal", 32'(m_ill), 1);

    // RV32E: reset in MEM_WAIT, stale response ignored, program reruns
    clr();
    imem[0] = 32'h8000_1137; imem[1] = 32'h0081_2203;
    imem[2] = 32'h0002_0513; imem[3] = EBRK;
    dmem[2] = 32'h0000_1234;
    ddelay = 6;
    do_reset(1);
    old = dacc; n = 0;
    while (dacc == old && n < 100) begin @(negedge clk); n++; end
    chk("e_mem_issued", 32'(dacc - old), 1);
    repeat (2) @(negedge clk);
    do_reset(1); wait_halt();
    chk("e_refetch", (flog.size() > 0) ? flog[0] : 32'hDEAD_BEEF, BASE);
    chk("e_illegal2", 32'(m_ill), 0);
    chk("e_lw_a0", m_hc, 32'h0000_1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
